// File: rtl/hex_to_screen_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hex_to_screen_pipe: 3-stage axial-hex to screen-space transform with     |
// | valid/ready. Optional clamp-on-overflow: `define HEX_SCREEN_SAT_EN.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hex_to_screen_pipe #(
   parameter int COORD_W   = 32,
   parameter int FRAC_BITS = 16,
   parameter int OUT_W     = 32,
   parameter int TAG_W     = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [COORD_W-1:0] q,
   input  logic [COORD_W-1:0] r,
   input  logic [COORD_W-1:0] s,
   input  logic [TAG_W-1:0]   in_tag,
   input  logic               pointy_top,
   input  logic [OUT_W-1:0]   hex_size,
   input  logic [OUT_W-1:0]   cam_x,
   input  logic [OUT_W-1:0]   cam_y,
   input  logic [OUT_W-1:0]   zoom,
   input  logic               snap_to_center,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_W-1:0]   screen_x,
   output logic [OUT_W-1:0]   screen_y,
   output logic [TAG_W-1:0]   out_tag,
   output logic               coord_err,
   output logic               sat
);

   localparam int W1 = 2*OUT_W + COORD_W;
   localparam int W3 = W1 + OUT_W + 1;
   localparam int CW = COORD_W + 2;

   // round(sqrt(3) * 2^f) by bitwise integer square root of 3 * 2^(2f)
   function automatic longint unsigned sqrt3_fixed(input int f);
      longint unsigned x;
      longint unsigned root;
      longint unsigned trial;
      x    = 64'd3 << (2*f);
      root = 64'd0;
      for (int i = 31; i >= 0; i--) begin
         trial = root | (64'd1 << i);
         if (trial * trial <= x) root = trial;
      end
      if (x - root * root > root) root = root + 64'd1;
      return root;
   endfunction

   localparam logic signed [W1-1:0] c_sqrt3      = W1'(sqrt3_fixed(FRAC_BITS));
   localparam logic signed [W1-1:0] c_half       = {{(W1-1){1'b0}}, 1'b1} << (FRAC_BITS-1);
   localparam logic signed [W1-1:0] c_three_half = c_half + (c_half <<< 1);
   localparam logic        [W1-1:0] c_int_mask   = {W1{1'b1}} << FRAC_BITS;
`ifdef HEX_SCREEN_SAT_EN
   localparam logic signed [W3-1:0] c_out_max    = {{(W3-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [W3-1:0] c_out_min    = ~c_out_max;
`endif

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             err;
      logic             snap;
      logic [OUT_W-1:0] cam_x;
      logic [OUT_W-1:0] cam_y;
      logic [OUT_W-1:0] zoom;
      logic [W1-1:0]    hx;
      logic [W1-1:0]    hy;
   } s1_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             err;
      logic [OUT_W-1:0] cam_x;
      logic [OUT_W-1:0] cam_y;
      logic [OUT_W-1:0] zoom;
      logic [W1-1:0]    wx;
      logic [W1-1:0]    wy;
   } s2_t;

   typedef struct packed {
      logic [OUT_W-1:0] x;
      logic [OUT_W-1:0] y;
      logic [TAG_W-1:0] tag;
      logic             err;
      logic             sat;
   } out_t;

   // {clamped, value}; wraps to the low OUT_W bits unless clamping is built in
   function automatic logic [OUT_W:0] reduce(input logic signed [W3-1:0] v);
`ifdef HEX_SCREEN_SAT_EN
      if (v > c_out_max) return {1'b1, c_out_max[OUT_W-1:0]};
      if (v < c_out_min) return {1'b1, c_out_min[OUT_W-1:0]};
`endif
      return {1'b0, v[OUT_W-1:0]};
   endfunction

   logic s1_valid_q, s1_valid_d;
   logic s2_valid_q, s2_valid_d;
   logic s3_valid_q, s3_valid_d;
   s1_t  s1_q, s1_d, s1_calc;
   s2_t  s2_q, s2_d, s2_calc;
   out_t out_q, out_d, out_calc;
   logic stall;

   assign stall    = s3_valid_q && !out_ready;
   assign in_ready = !stall;

   // Pointy and flat layouts share one datapath: the axis fed through sqrt(3)
   // is q (pointy) or r (flat), and the other axis takes the 3/2 term.
   always_comb begin
      logic signed [W1-1:0] maj;
      logic signed [W1-1:0] mnr;
      logic signed [W1-1:0] hs;
      logic signed [W1-1:0] rot;
      logic signed [W1-1:0] lin;
      logic signed [CW-1:0] csum;
      maj  = pointy_top ? W1'($signed(q)) : W1'($signed(r));
      mnr  = pointy_top ? W1'($signed(r)) : W1'($signed(q));
      hs   = W1'($signed(hex_size));
      rot  = (((((maj <<< FRAC_BITS) + mnr * c_half) * c_sqrt3) >>> FRAC_BITS) * hs) >>> FRAC_BITS;
      lin  = (mnr * c_three_half * hs) >>> FRAC_BITS;
      csum = CW'($signed(q)) + CW'($signed(r)) + CW'($signed(s));
      s1_calc.tag   = in_tag;
      s1_calc.err   = (csum != '0);
      s1_calc.snap  = snap_to_center;
      s1_calc.cam_x = cam_x;
      s1_calc.cam_y = cam_y;
      s1_calc.zoom  = zoom;
      s1_calc.hx    = pointy_top ? rot : lin;
      s1_calc.hy    = pointy_top ? lin : rot;
   end

   always_comb begin
      s2_calc.tag   = s1_q.tag;
      s2_calc.err   = s1_q.err;
      s2_calc.cam_x = s1_q.cam_x;
      s2_calc.cam_y = s1_q.cam_y;
      s2_calc.zoom  = s1_q.zoom;
      s2_calc.wx    = s1_q.snap ? ((s1_q.hx + c_half) & c_int_mask) : s1_q.hx;
      s2_calc.wy    = s1_q.snap ? ((s1_q.hy + c_half) & c_int_mask) : s1_q.hy;
   end

   always_comb begin
      logic signed [W3-1:0] z;
      logic signed [W3-1:0] px;
      logic signed [W3-1:0] py;
      logic [OUT_W:0]       rx;
      logic [OUT_W:0]       ry;
      z  = W3'($signed(s2_q.zoom));
      px = ((W3'($signed(s2_q.wx)) - W3'($signed(s2_q.cam_x))) * z) >>> FRAC_BITS;
      py = ((W3'($signed(s2_q.wy)) - W3'($signed(s2_q.cam_y))) * z) >>> FRAC_BITS;
      rx = reduce(px);
      ry = reduce(py);
      out_calc.x   = rx[OUT_W-1:0];
      out_calc.y   = ry[OUT_W-1:0];
      out_calc.tag = s2_q.tag;
      out_calc.err = s2_q.err;
      out_calc.sat = rx[OUT_W] | ry[OUT_W];
   end

   // The whole pipe moves as one unit; bubbles are kept while stalled.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      s3_valid_d = s3_valid_q;
      s1_d       = s1_q;
      s2_d       = s2_q;
      out_d      = out_q;
      if (!stall) begin
         s1_valid_d = in_valid;
         s2_valid_d = s1_valid_q;
         s3_valid_d = s2_valid_q;
         s1_d       = s1_calc;
         s2_d       = s2_calc;
         out_d      = out_calc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s3_valid_q <= 1'b0;
         out_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s3_valid_q <= s3_valid_d;
         out_q      <= out_d;
      end
   end

   always_ff @(posedge clk) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
   end

   assign out_valid = s3_valid_q;
   assign screen_x  = out_q.x;
   assign screen_y  = out_q.y;
   assign out_tag   = out_q.tag;
   assign coord_err = out_q.err;
   assign sat       = out_q.sat;

endmodule
`default_nettype wire

// File: doc/hex_to_screen_pipe.md
Name: hex_to_screen_pipe

Overview:
Parametrised, fully pipelined axial-hex to screen-space transform with valid/ready handshaking on both sides.
- Converts (q, r, s) plus a per-beat config snapshot into fixed-point screen coordinates.
- Three registered stages: hex→local, optional pixel snap, camera/zoom.
- Sits between the hex tile walker and the rasteriser setup stage. Supports back-pressure, a sideband tag, a cube-coordinate error flag, and an overflow flag.

Parameters:
COORD_W, 32, width of signed integer hex coordinates q/r/s
FRAC_BITS, 16, fractional bits of all fixed-point config and outputs (format Q(OUT_W-FRAC_BITS).FRAC_BITS)
OUT_W, 32, width of signed fixed-point config inputs and screen outputs
TAG_W, 8, width of opaque sideband tag carried alongside each beat

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
q  in  COORD_W  axial q (signed)
r  in  COORD_W  axial r (signed)
s  in  COORD_W  cube s (signed); must equal -q-r
in_tag  in  TAG_W  sideband tag
pointy_top  in  1  1 = pointy-top layout, 0 = flat-top layout
hex_size  in  OUT_W  hex size, fixed point
cam_x  in  OUT_W  camera x, fixed point
cam_y  in  OUT_W  camera y, fixed point
zoom  in  OUT_W  zoom factor, fixed point
snap_to_center  in  1  round local coords to the nearest integer pixel
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
screen_x  out  OUT_W  screen x, fixed point
screen_y  out  OUT_W  screen y, fixed point
out_tag  out  TAG_W  tag of this beat
coord_err  out  1  q+r+s != 0 for this beat
sat  out  1  output saturated (see Optional Feature)

Behaviour:
- Config (pointy_top, hex_size, cam_x, cam_y, zoom, snap_to_center) is sampled together with q/r/s on acceptance and carried down the pipe. Config changes never affect beats already in flight.
- Acceptance: a beat is accepted when in_valid && in_ready.
- Stall: stall = s3_valid && !out_ready.
  - in_ready = !stall, combinational from out_ready and s3_valid.
  - Every stage advances only when !stall; the whole pipe freezes as one unit while stalled.
  - Bubbles are not collapsed while stalled.
- Latency is 3 cycles from acceptance to out_valid with no stall. Throughput is 1 beat/cycle. Beat order is preserved, and no beat is dropped or duplicated under any out_ready pattern.
- Output hold: screen_x, screen_y, out_tag, coord_err and sat stay stable while out_valid && !out_ready.
- Constants, with F = FRAC_BITS:
  - SQRT3 = round(sqrt(3)·2^F) = 113512 for F=16
  - HALF = 2^(F-1)
  - THREE_HALF = 3·2^(F-1)
- Stage 1, internal width 2·OUT_W+COORD_W, signed; every `>>>` is an arithmetic shift (floor):
  - Pointy-top:
    - hx = ((((q<<F) + r·HALF)·SQRT3) >>> F)·hex_size >>> F
    - hy = (r·THREE_HALF·hex_size) >>> F
  - Flat-top:
    - hx = (q·THREE_HALF·hex_size) >>> F
    - hy = ((((r<<F) + q·HALF)·SQRT3) >>> F)·hex_size >>> F
  - coord_err = (q+r+s != 0), computed at COORD_W+2 bits.
- Stage 2:
  - If snap_to_center: w = (h + HALF) with the low F bits cleared (round half up).
  - Otherwise w = h.
- Stage 3:
  - sx = ((wx - cam_x)·zoom) >>> F
  - sy = ((wy - cam_y)·zoom) >>> F
  - Both are computed at full width, then reduced to OUT_W per the Optional Feature.
- coord_err is informational only: the arithmetic is still performed and the beat is still emitted.
- Reset:
  - All stage valids and out_valid go to 0; coord_err = 0; sat = 0; screen_x = screen_y = 0; out_tag = 0.
  - in_ready = 1 in the first cycle after reset deasserts.
  - Reset mid-stream discards all in-flight beats with no partial output.
  - Datapath registers need no reset other than the outputs listed above.

Optional Feature:
Macro HEX_SCREEN_SAT_EN.
- Defined: any stage-3 result outside the signed OUT_W range is clamped to 2^(OUT_W-1)-1 or -2^(OUT_W-1). sat = 1 if either axis clamped for that beat.
- Undefined: results are truncated to their low OUT_W bits (wrap) and sat is tied to 0.

Test Plan:
1. Pointy, q=1 r=0 s=-1, hex_size=65536, cam=0, zoom=65536, snap=0 → after 3 cycles screen_x=113512, screen_y=0, coord_err=0.
2. Same as 1 with snap=1 → screen_x=131072, screen_y=0. Same as 1 with cam_x=65536, zoom=131072 → screen_x=95952.
3. Flat, q=2 r=0 s=-2, size=65536, zoom=65536 → screen_x=196608, screen_y=113512.
4. Stream 6 tagged beats (tags 1..6) with out_ready low for 5 cycles mid-stream → in_ready low while stalled; outputs held stable; tags emerge 1..6 in order, none lost.
5. q=1 r=1 s=0 → coord_err=1 on that beat only; neighbouring beats have coord_err=0.
6. HEX_SCREEN_SAT_EN defined, q=30000, size=zoom=0x7FFFFFFF → screen_x=0x7FFFFFFF, sat=1. Assert reset with 3 beats in flight → out_valid=0 the next cycle and no stale beat afterwards.
